// File: rtl/dcache_control_nway.sv
// dcache_control_nway: N-way set-associative write-back data-cache controller.
// Sits between the CPU data port and the physical-memory port. It holds only
// the control state and the latched victim way; tag/valid/dirty/PLRU arrays
// live in the datapath. Optional performance counters are built when the
// macro DCACHE_PERF_CNT_EN is defined; otherwise hit_count, miss_count and
// wb_count are tied to zero and no counter flops exist.
module dcache_control_nway #(
    parameter int unsigned  NUM_WAYS   = 4,
    parameter int unsigned  LINE_BYTES = 32,
    localparam int unsigned WAY_W      = $clog2(NUM_WAYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [LINE_BYTES-1:0] mem_byte_enable256,
    output logic                  mem_resp,
    input  logic [NUM_WAYS-1:0]   hit_way,
    input  logic [NUM_WAYS-1:0]   valid_out,
    input  logic [NUM_WAYS-1:0]   dirty_out,
    input  logic [NUM_WAYS-2:0]   plru_in,
    output logic [NUM_WAYS-2:0]   plru_out,
    output logic                  load_plru,
    output logic [NUM_WAYS-1:0]   wren,
    output logic [LINE_BYTES-1:0] byte_en,
    output logic                  data_in_sel,
    output logic [NUM_WAYS-1:0]   load_tag,
    output logic [NUM_WAYS-1:0]   load_valid,
    output logic [NUM_WAYS-1:0]   load_dirty,
    output logic [NUM_WAYS-1:0]   set_valid,
    output logic [NUM_WAYS-1:0]   set_dirty,
    output logic [WAY_W-1:0]      victim_way,
    output logic                  pmem_addr_sel,
    output logic                  pmem_read,
    output logic                  pmem_write,
    input  logic                  pmem_resp,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           wb_count
);

    typedef enum logic [1:0] {
        ST_LOOKUP,
        ST_WR_COMMIT,
        ST_WRITE_BACK,
        ST_FILL
    } state_e;

    state_e             state_q, state_d;
    logic [WAY_W-1:0]   victim_q, victim_d;

    logic               req, is_write;
    logic               hit_any, inv_any;
    logic [WAY_W-1:0]   hit_idx, inv_idx, plru_vic, miss_vic;
    logic [NUM_WAYS-2:0] plru_upd;

    // Simultaneous read and write is treated as a read.
    assign req      = mem_read | mem_write;
    assign is_write = mem_write & ~mem_read;
    assign victim_way = victim_q;

    // Lowest-index priority for the hit way and for the first invalid way.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        inv_any = 1'b0;
        inv_idx = '0;
        for (int unsigned i = 0; i < NUM_WAYS; i++) begin
            if (hit_way[i] && !hit_any) begin
                hit_any = 1'b1;
                hit_idx = WAY_W'(i);
            end
            if (!valid_out[i] && !inv_any) begin
                inv_any = 1'b1;
                inv_idx = WAY_W'(i);
            end
        end
    end

    // Tree-PLRU: heap-ordered nodes; at depth d the node on way w's path is
    // (2^d - 1) + (w >> (WAY_W - d)), and the branch taken is bit WAY_W-1-d of w.
    always_comb begin
        int unsigned node;
        int unsigned pos;
        node     = 0;
        pos      = 0;
        plru_upd = plru_in;
        for (int unsigned d = 0; d < WAY_W; d++) begin
            node = (32'd1 << d) - 32'd1 + (32'(hit_idx) >> (WAY_W - d));
            plru_upd[node] = ~hit_idx[WAY_W-1-d];
        end
        for (int unsigned d = 0; d < WAY_W; d++) begin
            node = (32'd1 << d) - 32'd1 + pos;
            pos  = (pos << 1) | 32'(plru_in[node]);
        end
        plru_vic = WAY_W'(pos);
    end

    // Invalid ways are filled before any valid line is evicted.
    assign miss_vic = inv_any ? inv_idx : plru_vic;

    // Control state and latched victim.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOOKUP;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    // Next-state and all array/memory strobes.
    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        mem_resp      = 1'b0;
        plru_out      = '0;
        load_plru     = 1'b0;
        wren          = '0;
        byte_en       = '0;
        data_in_sel   = 1'b0;
        load_tag      = '0;
        load_valid    = '0;
        load_dirty    = '0;
        set_valid     = '0;
        set_dirty     = '0;
        pmem_addr_sel = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        unique case (state_q)
            ST_LOOKUP: begin
                if (req) begin
                    if (hit_any) begin
                        load_plru = 1'b1;
                        plru_out  = plru_upd;
                        if (is_write) begin
                            wren[hit_idx]       = 1'b1;
                            byte_en             = mem_byte_enable256;
                            load_dirty[hit_idx] = 1'b1;
                            set_dirty[hit_idx]  = 1'b1;
                            state_d             = ST_WR_COMMIT;
                        end else begin
                            mem_resp = 1'b1;
                        end
                    end else begin
                        victim_d = miss_vic;
                        state_d  = (valid_out[miss_vic] && dirty_out[miss_vic])
                                   ? ST_WRITE_BACK : ST_FILL;
                    end
                end
            end
            ST_WR_COMMIT: begin
                mem_resp = 1'b1;
                state_d  = ST_LOOKUP;
            end
            ST_WRITE_BACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                if (pmem_resp) begin
                    load_dirty[victim_q] = 1'b1;
                    state_d              = ST_FILL;
                end
            end
            ST_FILL: begin
                pmem_read   = 1'b1;
                data_in_sel = 1'b1;
                if (pmem_resp) begin
                    wren[victim_q]       = 1'b1;
                    byte_en              = '1;
                    load_tag[victim_q]   = 1'b1;
                    load_valid[victim_q] = 1'b1;
                    set_valid[victim_q]  = 1'b1;
                    load_dirty[victim_q] = 1'b1;
                    state_d              = ST_LOOKUP;
                end
            end
            default: state_d = ST_LOOKUP;
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
    logic        hit_evt, miss_evt, wb_evt;

    assign hit_evt  = (state_q == ST_LOOKUP) && req && hit_any;
    assign miss_evt = (state_q == ST_LOOKUP) && req && !hit_any;
    assign wb_evt   = (state_q == ST_WRITE_BACK) && pmem_resp;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (hit_evt)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_evt) miss_cnt_q <= miss_cnt_q + 32'd1;
            if (wb_evt)   wb_cnt_q   <= wb_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule
